// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, status bit positions and FSM states for the X-bus UART transmitter
package uart_tx_pkg;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;
    localparam logic [15:0] DIV_MIN = 16'd2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/xbus_uart_tx_byte_fifo.sv
// byte_fifo: synchronous 8-bit FIFO; pushes while full and pops while empty are ignored
module byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] count
);
    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic               do_push, do_pop;

    assign full    = count[FIFO_AW];
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_i)
        if (do_push) mem[wptr] <= wdata;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= do_push ? wptr + 1'b1 : wptr;
            rptr  <= do_pop ? rptr + 1'b1 : rptr;
            count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/xbus_uart_tx.sv
// xbus_uart_tx: X-bus slave with a 16-byte transmit FIFO serialised as 8N1 frames on txd_o
module xbus_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  xadr_i,
    input  logic [63:0] xdat_i,
    input  logic        xwe_i,
    input  logic        xstb_i,
    input  logic [1:0]  xsiz_i,
    input  logic        xsigned_i,
    output logic        xack_o,
    output logic [63:0] xdat_o,
    output logic        txd_o
);
    logic             accept, push, full, empty, ovf, pop, load, tdone, txd_n;
    logic [1:0]       sel;
    logic [7:0]       head, shreg, sh_n;
    logic [15:0]      div, div_lat, dl_n, timer, timer_n;
    logic [2:0]       bitcnt, bit_n;
    logic [FIFO_AW:0] count;
    logic [63:0]      status, rdata;
    tx_state_t        state, state_n;
    logic             unused_ok;

    assign unused_ok = ^{xsiz_i, xsigned_i, xadr_i[2:0], xdat_i[63:16]};
    assign accept    = xstb_i & ~xack_o;
    assign sel       = xadr_i[4:3];
    assign push      = accept & xwe_i & (sel == REG_TXDATA);

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push(push), .wdata(xdat_i[7:0]), .pop(pop),
        .rdata(head), .full(full), .empty(empty), .count(count)
    );

    always_comb begin
        status                         = '0;
        status[ST_FULL]                = full;
        status[ST_EMPTY]               = empty;
        status[ST_BUSY]                = state != IDLE;
        status[ST_OVF]                 = ovf;
        status[ST_COUNT +: FIFO_AW+1]  = count;
    end

    assign rdata = sel == REG_STATUS  ? status :
                   sel == REG_DIVISOR ? {48'b0, div} : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            xack_o <= 1'b0;
            xdat_o <= '0;
            div    <= DEFAULT_DIV;
            ovf    <= 1'b0;
        end else begin
            xack_o <= accept;
            xdat_o <= (accept & ~xwe_i) ? rdata : '0;
            if (push & full)
                ovf <= 1'b1;
            else if (accept & xwe_i & (sel == REG_STATUS))
                ovf <= 1'b0;
            if (accept & xwe_i & (sel == REG_DIVISOR))
                div <= xdat_i[15:0] < DIV_MIN ? DIV_MIN : xdat_i[15:0];
        end
    end

    assign tdone = timer == '0;
    // a new frame is loaded from IDLE or straight out of the last stop-bit clock
    assign load  = ~empty & ((state == IDLE) | ((state == STOP) & tdone));

    always_comb begin
        state_n = state;
        timer_n = state != IDLE ? timer - 16'd1 : timer;
        bit_n   = bitcnt;
        sh_n    = shreg;
        dl_n    = div_lat;
        txd_n   = txd_o;
        pop     = 1'b0;
        case (state)
            START: if (tdone) begin
                state_n = DATA;
                timer_n = div_lat - 16'd1;
                bit_n   = 3'd0;
                txd_n   = shreg[0];
            end
            DATA: if (tdone) begin
                timer_n = div_lat - 16'd1;
                if (bitcnt == 3'd7) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    bit_n = bitcnt + 3'd1;
                    sh_n  = {1'b0, shreg[7:1]};
                    txd_n = shreg[1];
                end
            end
            STOP: if (tdone) state_n = IDLE;
            default: ;
        endcase
        if (load) begin
            pop     = 1'b1;
            sh_n    = head;
            dl_n    = div;
            timer_n = div - 16'd1;
            txd_n   = 1'b0;
            state_n = START;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            timer   <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            div_lat <= DEFAULT_DIV;
            txd_o   <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bitcnt  <= bit_n;
            shreg   <= sh_n;
            div_lat <= dl_n;
            txd_o   <= txd_n;
        end
    end
endmodule

// File: tb/tb_xbus_uart_tx.sv
// tb_xbus_uart_tx: directed and randomized checks of bus handshake, registers and 8N1 waveform
module tb_xbus_uart_tx;
    logic        clk = 1'b0, reset = 1'b1, xwe = 1'b0, xstb = 1'b0, xsigned = 1'b0;
    logic [4:0]  xadr = '0;
    logic [63:0] xdat_in = '0;
    logic [1:0]  xsiz = '0;
    logic        xack, txd;
    logic [63:0] xdat_out;
    int          passed = 0, failed = 0, total = 0, cyc = 0;
    logic        txlog [0:65535];
    logic        expq [$];

    xbus_uart_tx dut (
        .clk_i(clk), .reset_i(reset), .xadr_i(xadr), .xdat_i(xdat_in), .xwe_i(xwe),
        .xstb_i(xstb), .xsiz_i(xsiz), .xsigned_i(xsigned), .xack_o(xack), .xdat_o(xdat_out),
        .txd_o(txd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc < 65536) txlog[cyc] <= txd;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [4:0] adr, input logic [63:0] dat, output logic [63:0] rd);
        @(negedge clk);
        xadr = adr; xdat_in = dat; xwe = we; xstb = 1'b1;
        xsiz = 2'($urandom_range(0, 3)); xsigned = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("ack_latency", xack, 1'b1);
        rd = xdat_out;
        xstb = 1'b0; xwe = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [63:0] dat);
        logic [63:0] dummy;
        bus(1'b1, adr, dat, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] adr, input logic [63:0] exp);
        logic [63:0] d;
        bus(1'b0, adr, '0, d);
        check(tag, d, exp);
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        for (int k = 0; k < 10; k++)
            repeat (d) expq.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1]);
    endtask

    task automatic check_wave(input string tag, input int start);
        int mism = 0;
        while (cyc <= start + expq.size() + 1) @(negedge clk);
        if (txlog[start-1] !== 1'b1) mism++;
        foreach (expq[i]) if (txlog[start+i] !== expq[i]) mism++;
        if (txlog[start+expq.size()] !== 1'b1) mism++;
        check(tag, 64'(mism), 64'd0);
        expq.delete();
    endtask

    initial begin
        int start, d, n;
        logic [7:0] b;
        logic [3:0] pat;
        logic [15:0] v;
        repeat (3) @(negedge clk);
        check("reset_ack", xack, 1'b0);
        check("reset_xdat", xdat_out, 64'd0);
        check("reset_txd", txd, 1'b1);
        reset = 1'b0;
        rd_check("reset_status", 5'h08, 64'h2);
        rd_check("reset_div", 5'h10, 64'd434);

        wr(5'h10, 64'd4);
        rd_check("div4", 5'h10, 64'd4);
        wr(5'h00, 64'hA5);
        start = cyc + 1;
        add_frame(8'hA5, 4);
        repeat (6) @(negedge clk);
        rd_check("busy_early", 5'h08, 64'h6);
        repeat (24) @(negedge clk);
        rd_check("busy_late", 5'h08, 64'h6);
        check_wave("frame_a5", start);
        rd_check("idle_after_a5", 5'h08, 64'h2);

        wr(5'h10, 64'd2);
        wr(5'h00, 64'h00);
        start = cyc + 1;
        wr(5'h00, 64'hFF);
        add_frame(8'h00, 2);
        add_frame(8'hFF, 2);
        check_wave("back_to_back", start);
        rd_check("b2b_status", 5'h08, 64'h2);

        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(2, 5);
            n = $urandom_range(1, 3);
            wr(5'h10, 64'(d));
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                wr(5'h00, {$urandom, $urandom, 24'h0, b} & 64'hFFFF_FFFF_FFFF_FFFF);
                if (j == 0) start = cyc + 1;
                add_frame(b, d);
            end
            check_wave("rand_frames", start);
        end

        wr(5'h10, 64'd0);
        rd_check("clamp0", 5'h10, 64'd2);
        for (int it = 0; it < 3; it++) begin
            v = 16'($urandom_range(0, 6));
            wr(5'h10, {48'hDEAD_BEEF_0000, v});
            rd_check("div_rand", 5'h10, 64'(v < 2 ? 16'd2 : v));
        end
        wr(5'h10, 64'd7);
        wr(5'h18, 64'd99);
        rd_check("unmapped_write", 5'h10, 64'd7);
        rd_check("unmapped_read", 5'h18, 64'd0);
        rd_check("txdata_read", 5'h00, 64'd0);
        @(negedge clk);
        xadr = 5'h08; xwe = 1'b0; xstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = xack;
        end
        xstb = 1'b0;
        check("hold_acks", 64'(pat), 64'h5);
        @(negedge clk);
        check("xdat_idle_zero", xdat_out, 64'd0);

        wr(5'h10, 64'd1000);
        for (int i = 0; i < 18; i++) wr(5'h00, 64'($urandom_range(0, 255)));
        rd_check("overflow_status", 5'h08, 64'h100D);
        wr(5'h08, 64'd0);
        rd_check("overflow_clear", 5'h08, 64'h1005);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_clears_fifo_txd", txd, 1'b1);
        rd_check("reset_clears_fifo", 5'h08, 64'h2);

        wr(5'h10, 64'd4);
        wr(5'h00, 64'h00);
        repeat (6) @(negedge clk);
        check("in_data_bit", txd, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_txd", txd, 1'b1);
        reset = 1'b0;
        rd_check("midframe_status", 5'h08, 64'h2);
        rd_check("midframe_div", 5'h10, 64'd434);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/xbus_uart_tx.md
Name: xbus_uart_tx

Overview:
- Memory-mapped serial transmitter; a sequential responder (slave) on the arbiter's external X-bus, beside the boot ROM in the address map.
- The CPU D-port writes bytes into a transmit FIFO through the arbiter. The block serialises them as 8N1 frames on txd_o.
- Unlike the combinational ROM decode, it acknowledges with registered timing.
- It exposes status and baud-divisor registers.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (16 entries).
- DEFAULT_DIV, 16'd434, reset value of the bit-period divisor, in clocks per bit.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- xadr_i  in  5  byte offset within the block (xadr[4:0]); bits [4:3] select the register.
- xdat_i  in  64  write data, right-justified.
- xwe_i  in  1  1 = write, 0 = read.
- xstb_i  in  1  request strobe; held by the initiator until acknowledged.
- xsiz_i  in  2  access size (0 = byte, 1 = half, 2 = word, 3 = dword); no effect on the result.
- xsigned_i  in  1  ignored; read data is always zero-extended.
- xack_o  out  1  one-cycle acknowledge.
- xdat_o  out  64  read data, valid while xack_o = 1.
- txd_o  out  1  serial output; idle level is high.

Behaviour:
- Reset, applied on any clk_i edge with reset_i = 1 (including mid-frame):
  - xack_o = 0, xdat_o = 0, txd_o = 1.
  - FIFO emptied, FSM forced to IDLE.
  - Divisor = DEFAULT_DIV, overflow flag = 0.
- Handshake:
  - A request is accepted in a cycle with xstb_i & ~xack_o.
  - xack_o = 1 in the following cycle, for exactly one cycle.
  - A strobe still high during the ack cycle is not re-accepted; throughput is one access per 2 clocks.
  - Every access is acked, including unmapped offsets and rejected pushes. Latency is fixed at 1.
- Register map, selected by xadr_i[4:3]:
  - 0 TXDATA:
    - Write pushes xdat_i[7:0].
    - Read returns 0.
  - 1 STATUS, read:
    - bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow.
    - bits[8+FIFO_AW:8] = FIFO count.
    - All other bits 0.
  - 1 STATUS, write: any write clears overflow.
  - 2 DIVISOR:
    - Read returns the 16-bit divisor, zero-extended.
    - Write loads xdat_i[15:0]; values < 2 are stored as 2.
  - 3: reads return 0; writes have no effect.
- Read data and status are sampled in the accept cycle and registered into xdat_o. xdat_o returns to 0 when xack_o = 0.
- FIFO:
  - Depth 2^FIFO_AW; pointers wrap modulo depth.
  - A push while full (judged on the pre-cycle count, even if a pop occurs in the same cycle) is dropped and sets overflow.
  - Push to a non-full FIFO with a simultaneous pop: count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd_o = 1. If the FIFO is non-empty: pop the head byte into the shift register, latch the divisor, go to START.
  - START: txd_o = 0 for DIV clocks.
  - DATA: 8 bits LSB first, DIV clocks each; a 3-bit counter tracks the bit index.
  - STOP: txd_o = 1 for DIV clocks. At the end: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Timing:
  - The bit timer counts DIV-1 down to 0.
  - A frame is exactly 10*DIV clocks. The first start bit appears 1 clock after the pop cycle.
  - A divisor written mid-frame takes effect at the next frame's start.
- txd_o is driven from a flop (glitch-free).

Decomposition:
- Package uart_tx_pkg holds:
  - register offset constants (REG_TXDATA, REG_STATUS, REG_DIVISOR);
  - STATUS bit-position constants;
  - the FSM state enum;
  - the divisor minimum (2).
- Sub-module byte_fifo: a synchronous 8-bit-wide FIFO parameterised by FIFO_AW, with push, pop, full, empty and count.
- The X-bus decode, registers and serialiser FSM stay in xbus_uart_tx.

Test Plan:
- Reset: hold reset_i for 3 cycles, then read STATUS -> xdat_o = 64'h2 (empty), txd_o = 1, DIVISOR reads 434.
- Single frame: write DIVISOR = 4, then write TXDATA = 8'hA5 -> the ack comes 1 cycle after strobe; txd_o carries a start bit (0) of 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then a stop bit of 4 clocks. Total frame = 40 clocks; busy = 1 throughout.
- Back-to-back: with DIVISOR = 2, push 8'h00 then 8'hFF -> the second start bit follows the first stop bit with no idle gap; STATUS ends at 64'h2.
- Overflow: with DIVISOR = 1000, push 18 bytes -> STATUS shows full = 1, overflow = 1, count = 16 (one byte already in the shifter, one dropped); a write to STATUS clears bit3.
- Clamp and unmapped: write DIVISOR = 0 -> reads back 2; a read at offset 5'h18 returns 0 with xack_o; holding xstb_i high for 4 cycles yields exactly 2 acks, alternating.
- Mid-frame reset: assert reset_i during DATA -> the next cycle txd_o = 1, STATUS = 64'h2, DIVISOR = 434.
